fetch_inst_fifo: RTL and testbench

Instruction buffer between the fetch stage and decode. It accepts one fetched instruction pair per cycle with its PC, prediction and exception metadata, and stores pairs in a circular queue. It presents the oldest pair to decode as the fifo_id_* bundle consumed by the decode/issue register. It decouples fetch from decode/issue stalls and discards all contents on pipeline flush.

---
 rtl/fetch_inst_fifo_pkg.sv | 33 +++
 rtl/fetch_fifo_mem.sv | 25 ++
 rtl/fetch_inst_fifo.sv | 99 +++++++++
 tb/tb_fetch_inst_fifo.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/fetch_inst_fifo_pkg.sv
// Shared types and constants for the fetch-to-decode instruction pair buffer.
// One packet carries a fetched pair with its PCs, prediction and exception metadata.
package fetch_inst_fifo_pkg;

  localparam logic [31:0] INST_NOP = 32'h0340_0000;
  localparam logic [6:0]  EXP_ADEF = 7'h08;

  typedef struct packed {
    logic [31:0] inst0;
    logic [31:0] inst1;
    logic [31:0] pc0;
    logic [31:0] pc1;
    logic [31:0] pc_next;
    logic        pc_taken;
    logic [31:0] badv;
    logic [1:0]  excp_flag;
    logic [6:0]  exception;
    logic [1:0]  priv_flag;
    logic [1:0]  branch_flag;
  } fetch_pkt_t;

  localparam int PKT_W = $bits(fetch_pkt_t);

  // Value decode sees when nothing is buffered.
  function automatic fetch_pkt_t idle_pkt();
    fetch_pkt_t p;
    p       = '0;
    p.inst0 = INST_NOP;
    p.inst1 = INST_NOP;
    return p;
  endfunction

endpackage

// File: rtl/fetch_fifo_mem.sv
// Packet storage: one synchronous write port, one asynchronous read port.
// No reset; occupancy is tracked by the owning FIFO.
module fetch_fifo_mem
  import fetch_inst_fifo_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             aclk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  fetch_pkt_t       wdata,
  input  logic [PTR_W-1:0] raddr,
  output fetch_pkt_t       rdata
);

  fetch_pkt_t mem [DEPTH];

  always_ff @(posedge aclk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_inst_fifo.sv
// Instruction-pair buffer between fetch and decode: circular queue with
// registered full/empty, no bypass, flush discards everything.
module fetch_inst_fifo
  import fetch_inst_fifo_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        flush,
  input  logic        if_readygo,
  output logic        fifo_allowin,
  input  logic [31:0] if_inst0,
  input  logic [31:0] if_inst1,
  input  logic [31:0] if_pc0,
  input  logic [31:0] if_pc1,
  input  logic [31:0] if_pc_next,
  input  logic        if_pc_taken,
  input  logic [31:0] if_badv,
  input  logic [1:0]  if_excp_flag,
  input  logic [6:0]  if_exception,
  input  logic [1:0]  if_priv_flag,
  input  logic [1:0]  if_branch_flag,
  output logic        fifo_readygo,
  input  logic        id_allowin,
  output logic [31:0] fifo_id_inst0,
  output logic [31:0] fifo_id_inst1,
  output logic [31:0] fifo_id_pc0,
  output logic [31:0] fifo_id_pc1,
  output logic [31:0] fifo_id_pc_next,
  output logic        fifo_id_pc_taken,
  output logic [31:0] fifo_id_badv,
  output logic [1:0]  fifo_id_excp_flag,
  output logic [6:0]  fifo_id_exception,
  output logic [1:0]  fifo_id_priv_flag,
  output logic [1:0]  fifo_id_branch_flag
);

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             full, empty, push, pop, clr;
  fetch_pkt_t       wr_pkt, rd_pkt, head;

  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign empty = (count == '0);
  assign clr   = ~aresetn | flush;

  // Handshakes depend only on registered occupancy, never on the far side's ready.
  assign push = if_readygo & ~full;
  assign pop  = ~empty & id_allowin;

  always_ff @(posedge aclk) begin
    if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign wr_pkt = '{inst0: if_inst0, inst1: if_inst1, pc0: if_pc0, pc1: if_pc1,
                    pc_next: if_pc_next, pc_taken: if_pc_taken, badv: if_badv,
                    excp_flag: if_excp_flag, exception: if_exception,
                    priv_flag: if_priv_flag, branch_flag: if_branch_flag};

  fetch_fifo_mem #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_mem (
    .aclk  (aclk),
    .we    (push & ~clr),
    .waddr (wr_ptr),
    .wdata (wr_pkt),
    .raddr (rd_ptr),
    .rdata (rd_pkt)
  );

  assign head = empty ? idle_pkt() : rd_pkt;

  assign fifo_allowin        = ~full;
  assign fifo_readygo        = ~empty;
  assign fifo_id_inst0       = head.inst0;
  assign fifo_id_inst1       = head.inst1;
  assign fifo_id_pc0         = head.pc0;
  assign fifo_id_pc1         = head.pc1;
  assign fifo_id_pc_next     = head.pc_next;
  assign fifo_id_pc_taken    = head.pc_taken;
  assign fifo_id_badv        = head.badv;
  assign fifo_id_excp_flag   = head.excp_flag;
  assign fifo_id_exception   = head.exception;
  assign fifo_id_priv_flag   = head.priv_flag;
  assign fifo_id_branch_flag = head.branch_flag;

endmodule

// File: tb/tb_fetch_inst_fifo.sv
// Scoreboard bench for fetch_inst_fifo: a queue model updated from the offered
// stimulus each edge; a negedge monitor compares handshakes and head fields.
module tb_fetch_inst_fifo;
  import fetch_inst_fifo_pkg::*;

  localparam int DEPTH = 8;

  logic        aclk = 0;
  logic        aresetn, flush, if_readygo, id_allowin;
  logic        fifo_allowin, fifo_readygo;
  fetch_pkt_t  pkt_in, dut_head;
  logic [31:0] fifo_id_inst0, fifo_id_inst1, fifo_id_pc0, fifo_id_pc1, fifo_id_pc_next, fifo_id_badv;
  logic        fifo_id_pc_taken;
  logic [1:0]  fifo_id_excp_flag, fifo_id_priv_flag, fifo_id_branch_flag;
  logic [6:0]  fifo_id_exception;

  fetch_pkt_t q[$];
  int  errors = 0, checks = 0;
  bit  mon_en = 0;

  always #5 aclk = ~aclk;

  fetch_inst_fifo #(.DEPTH(DEPTH)) dut (
    .aclk(aclk), .aresetn(aresetn), .flush(flush),
    .if_readygo(if_readygo), .fifo_allowin(fifo_allowin),
    .if_inst0(pkt_in.inst0), .if_inst1(pkt_in.inst1),
    .if_pc0(pkt_in.pc0), .if_pc1(pkt_in.pc1), .if_pc_next(pkt_in.pc_next),
    .if_pc_taken(pkt_in.pc_taken), .if_badv(pkt_in.badv),
    .if_excp_flag(pkt_in.excp_flag), .if_exception(pkt_in.exception),
    .if_priv_flag(pkt_in.priv_flag), .if_branch_flag(pkt_in.branch_flag),
    .fifo_readygo(fifo_readygo), .id_allowin(id_allowin),
    .fifo_id_inst0(fifo_id_inst0), .fifo_id_inst1(fifo_id_inst1),
    .fifo_id_pc0(fifo_id_pc0), .fifo_id_pc1(fifo_id_pc1),
    .fifo_id_pc_next(fifo_id_pc_next), .fifo_id_pc_taken(fifo_id_pc_taken),
    .fifo_id_badv(fifo_id_badv), .fifo_id_excp_flag(fifo_id_excp_flag),
    .fifo_id_exception(fifo_id_exception), .fifo_id_priv_flag(fifo_id_priv_flag),
    .fifo_id_branch_flag(fifo_id_branch_flag)
  );

  assign dut_head = '{inst0: fifo_id_inst0, inst1: fifo_id_inst1, pc0: fifo_id_pc0,
                      pc1: fifo_id_pc1, pc_next: fifo_id_pc_next, pc_taken: fifo_id_pc_taken,
                      badv: fifo_id_badv, excp_flag: fifo_id_excp_flag,
                      exception: fifo_id_exception, priv_flag: fifo_id_priv_flag,
                      branch_flag: fifo_id_branch_flag};

  // Reference model: a bounded queue; full blocks the offer even if decode pops.
  always @(posedge aclk) begin
    bit do_push, do_pop;
    if (!aresetn || flush) q.delete();
    else begin
      do_push = if_readygo && (q.size() < DEPTH);
      do_pop  = id_allowin && (q.size() > 0);
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(pkt_in);
    end
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge aclk) begin
    if (mon_en) begin
      fetch_pkt_t exp_head;
      exp_head = (q.size() != 0) ? q[0] : idle_pkt();
      check("readygo", 256'(fifo_readygo), 256'(q.size() != 0));
      check("allowin", 256'(fifo_allowin), 256'(q.size() != DEPTH));
      check("head",    256'(dut_head),     256'(exp_head));
    end
  end

  function automatic fetch_pkt_t rnd_pkt(input logic [31:0] pc);
    fetch_pkt_t p;
    p.inst0       = $urandom;
    p.inst1       = $urandom;
    p.pc0         = pc;
    p.pc1         = pc + 32'd4;
    p.pc_next     = $urandom;
    p.pc_taken    = 1'($urandom_range(1));
    p.badv        = $urandom;
    p.excp_flag   = 2'($urandom_range(3));
    p.exception   = 7'($urandom_range(127));
    p.priv_flag   = 2'($urandom_range(3));
    p.branch_flag = 2'($urandom_range(3));
    return p;
  endfunction

  task automatic step(input bit rg, input fetch_pkt_t p, input bit ida,
                      input bit fl = 0, input bit rn = 1);
    @(negedge aclk);
    if_readygo = rg; pkt_in = p; id_allowin = ida; flush = fl; aresetn = rn;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, rnd_pkt($urandom), 0);
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) step(1, rnd_pkt(32'h1c00_1000 + 32'(i) * 8), 0);
  endtask

  initial begin
    fetch_pkt_t p;
    aresetn = 0; flush = 0; if_readygo = 0; id_allowin = 0; pkt_in = '0;
    @(posedge aclk); #1 mon_en = 1;
    step(0, '0, 0, 0, 0);
    idle(1);

    // Single push, then pop back to idle outputs.
    p = rnd_pkt(32'h1c00_0000);
    p.inst0 = 32'h0280_0421;
    step(1, p, 0);
    idle(1);
    step(0, '0, 1);
    idle(2);

    // Fill to full with decode stalled, 9th offer refused, then drain in order.
    for (int k = 0; k < 9; k++) step(1, rnd_pkt(32'h1c00_0000 + 32'(k) * 8), 0);
    for (int k = 0; k < 9; k++) step(0, '0, 1);

    // Steady-state push+pop at count=3, wrapping the pointers.
    step(0, '0, 0, 1);
    fill(3);
    for (int k = 0; k < 20; k++) step(1, rnd_pkt(32'h1c00_2000 + 32'(k) * 8), 1);
    step(0, '0, 1, 1);

    // Flush at count=5 beats a simultaneous push and pop.
    fill(5);
    step(1, rnd_pkt(32'h1c00_3000), 1, 1);
    step(1, rnd_pkt(32'h1c00_3008), 0);
    step(0, '0, 1);

    // Exception metadata forwarded unchanged.
    p = rnd_pkt(32'h1c00_0000);
    p.excp_flag = 2'b01; p.exception = EXP_ADEF; p.badv = 32'h1c00_0003;
    step(1, p, 0);
    step(0, '0, 1);
    idle(1);

    // Reset pulse at count=6, then normal traffic.
    fill(6);
    step(1, rnd_pkt(32'h1c00_4000), 1, 0, 0);
    step(1, rnd_pkt(32'h1c00_5000), 0);
    step(1, rnd_pkt(32'h1c00_5008), 1);
    step(0, '0, 1);

    // Random traffic with occasional flush and reset.
    for (int k = 0; k < 400; k++)
      step($urandom_range(99) < 70, rnd_pkt($urandom), $urandom_range(99) < 55,
           $urandom_range(99) < 2, !($urandom_range(99) < 1));
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
